// File: rtl/ads_bus_pkg.sv
// ads_bus_pkg
//   Shared definitions for the ADS serial bus. The slave FSM state type,
//   the rw and status bit encodings, and small sizing helpers live here so
//   that the slave and the masters' bus models agree on them.
package ads_bus_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RX_RW,
    S_RX_ADDR,
    S_RX_DATA,
    S_RESP,
    S_TX_START,
    S_TX_STATUS,
    S_TX_DATA
  } ads_slv_state_t;

  localparam logic RW_READ    = 1'b0;
  localparam logic RW_WRITE   = 1'b1;
  localparam logic STATUS_OK  = 1'b1;
  localparam logic STATUS_ERR = 1'b0;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Counter width able to index n bits; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ads_slv_regfile.sv
// ads_slv_regfile
//   DEPTH x DATA_W register array backing the ADS memory slave.
//   All words clear on asynchronous reset. One synchronous write port and
//   one combinational read port share the same address; in_range flags
//   whether that address maps to an implemented word.
// Ports
//   clk      in   1       clock, rising edge
//   rst      in   1       asynchronous active-high reset, clears all words
//   we       in   1       write enable (ignored when the address is out of range)
//   addr     in   ADDR_W  word address for both read and write
//   din      in   DATA_W  write data
//   dout     out  DATA_W  read data (0 when out of range)
//   in_range out  1       addr < DEPTH
module ads_slv_regfile #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              in_range
);

  logic [DATA_W-1:0] mem [DEPTH];

  // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
  assign in_range = ({1'b0, addr} < (ADDR_W + 1)'(DEPTH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we && in_range) begin
      mem[addr] <= din;
    end
  end

  assign dout = in_range ? mem[addr] : '0;

endmodule

// File: rtl/ads_mem_slave.sv
// ads_mem_slave
//   Memory-backed responder on the ADS serial bus. A request frame arrives
//   bit-serially on rx (start, rw, address LSB first, write data LSB first),
//   is executed against ads_slv_regfile, and a response frame (start,
//   status, read data LSB first for successful reads) is sent on tx.
//   busy holds the response and the write commit while the FSM sits in RESP.
// Ports
//   clk     in   1       clock, rising edge
//   rst     in   1       asynchronous active-high reset
//   rx      in   1       serial request, idle low
//   tx      out  1       serial response, idle low
//   busy    in   1       defer response and write commit
//   wdata   out  DATA_W  last committed write word
//   wvalid  out  1       one-cycle pulse on each write commit
module ads_mem_slave
  import ads_bus_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  output logic              tx,
  input  logic              busy,
  output logic [DATA_W-1:0] wdata,
  output logic              wvalid
);

  localparam int CNT_W = cnt_width(max_int(ADDR_W, DATA_W));
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

  ads_slv_state_t    state;
  ads_slv_state_t    state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic              rw;
  logic [ADDR_W-1:0] addr_sr;
  logic [DATA_W-1:0] data_sr;
  logic [DATA_W-1:0] rdata;
  logic              in_range;
  logic              commit;

  ads_slv_regfile #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .we       (commit),
    .addr     (addr_sr),
    .din      (data_sr),
    .dout     (rdata),
    .in_range (in_range)
  );

  // Control state: FSM, bit counter, rw flag and the write-commit outputs.
  // The counter restarts on every state change, so each shifting state
  // sees it count from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      rw     <= RW_READ;
      wvalid <= 1'b0;
      wdata  <= '0;
    end else begin
      state  <= state_nxt;
      cnt    <= (state_nxt != state) ? '0 : cnt + CNT_W'(1);
      if (state == S_RX_RW) begin
        rw <= rx;
      end
      wvalid <= commit;
      if (commit) begin
        wdata <= data_sr;
      end
    end
  end

  // Shift registers. Both are fully reloaded by every frame, so they need
  // no reset. data_sr carries the received write word and, after the
  // status bit, the word being read back.
  always_ff @(posedge clk) begin
    case (state)
      S_RX_ADDR:   addr_sr <= {rx, addr_sr[ADDR_W-1:1]};
      S_RX_DATA:   data_sr <= {rx, data_sr[DATA_W-1:1]};
      S_TX_STATUS: data_sr <= rdata;
      S_TX_DATA:   data_sr <= {1'b0, data_sr[DATA_W-1:1]};
      default:     ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    tx        = 1'b0;
    commit    = 1'b0;
    case (state)
      S_IDLE: begin
        if (rx) state_nxt = S_RX_RW;
      end
      S_RX_RW: begin
        state_nxt = S_RX_ADDR;
      end
      S_RX_ADDR: begin
        if (cnt == ADDR_LAST) begin
          state_nxt = (rw == RW_WRITE) ? S_RX_DATA : S_RESP;
        end
      end
      S_RX_DATA: begin
        if (cnt == DATA_LAST) state_nxt = S_RESP;
      end
      S_RESP: begin
        if (!busy) begin
          commit    = (rw == RW_WRITE) && in_range;
          state_nxt = S_TX_START;
        end
      end
      S_TX_START: begin
        tx        = 1'b1;
        state_nxt = S_TX_STATUS;
      end
      S_TX_STATUS: begin
        tx        = in_range ? STATUS_OK : STATUS_ERR;
        state_nxt = ((rw == RW_READ) && in_range) ? S_TX_DATA : S_IDLE;
      end
      S_TX_DATA: begin
        tx = data_sr[0];
        if (cnt == DATA_LAST) state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule
